ifetch: RTL and testbench
=========================

# ifetch

Instruction fetch sequencer for the SimpleCPU datapath, sitting between the program counter, instruction memory and the decoder. It reads memory at the address held by the PC and hands each instruction word to the decoder through a valid/ready handshake. It drives the PC control inputs: `ipc` to advance after a fetch, and `epc` plus `pc_data` to redirect on a taken branch. It is the controlling end of the PC's increment/load interface.

## Interface
- `TIMEOUT`, 255, memory-ack watchdog limit in cycles, 1..255; used only when `IFETCH_TIMEOUT_EN` is defined.
- `clk`  in  1  single clock; all flops on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `pc_in`  in  16  current PC value (PC `pcout`).
- `ipc`  out  1  PC increment request, one-cycle pulse.
- `epc`  out  1  PC load request, one-cycle pulse.
- `pc_data`  out  16  PC load value. The PC loads `pc_data - 1` on `epc`.
- `mem_req`  out  1  instruction memory read request.
- `mem_addr`  out  16  read address, continuously equal to `pc_in`.
- `mem_ack`  in  1  read complete; `mem_rdata` is valid in the same cycle.
- `mem_rdata`  in  16  instruction word.
- `ir_out`  out  16  fetched instruction.
- `ir_valid`  out  1  `ir_out` holds an unconsumed instruction.
- `ir_ready`  in  1  decoder accepts `ir_out`.
- `br_take`  in  1  redirect request, single-cycle pulse.
- `br_target`  in  16  redirect address, sampled with `br_take`.
- `fault`  out  1  sticky memory timeout flag; tied 0 when the watchdog is compiled out.

## Operation
- States: IDLE, FETCH, HOLD, REDIRECT, FAULT.
- Transitions:
  - IDLE → FETCH unconditionally.
  - FETCH: `mem_req`=1. Stays in FETCH until `mem_ack`.
    - On ack with no branch pending: capture `mem_rdata` into `ir_out`, set `ir_valid`, pulse `ipc` in the next cycle, go to HOLD.
    - On ack with a branch pending (or `br_take` in the ack cycle): discard the data, no `ipc`, go to REDIRECT.
  - HOLD: `ir_valid`=1.
    - `ir_ready` → clear `ir_valid`, go to FETCH.
    - `br_take` → clear `ir_valid`, go to REDIRECT. `br_take` wins over `ir_ready`; the instruction is treated as consumed.
  - REDIRECT: `epc`=1 and `pc_data = br_target_latched + 1` (mod 2^16) for exactly one cycle, then FETCH.
- Branch latch:
  - `br_take` in any state latches `br_target` and sets `br_pend`.
  - `br_pend` clears on REDIRECT exit.
  - A second `br_take` before that overwrites the latched target. Last target wins.
- `ipc` and `epc` are never high in the same cycle.
- The request is never abandoned; a memory read once started always completes.
- Wrap-around:
  - `br_target` = 0xFFFF → `pc_data` = 0x0000, so the PC loads 0xFFFF.
  - PC wrap from 0xFFFF to 0 is the PC's job; `ifetch` just follows `pc_in`.

## Timing
- All outputs are registered except `mem_addr`.
- Reset values: `ipc`=0, `epc`=0, `pc_data`=0, `mem_req`=0, `ir_out`=0, `ir_valid`=0, `fault`=0, state=IDLE, `br_pend`=0.
- `mem_req` rises the cycle after reset release (IDLE→FETCH).
- `mem_req` and `mem_addr` stay stable until the ack cycle. `mem_req` is low the cycle after ack.
- Ack at cycle N gives `ir_valid`=1 and `ipc`=1 in cycle N+1. The PC updates at the end of N+1.
- Minimum fetch period is 3 cycles with zero-wait memory and `ir_ready` held high:
  - FETCH(ack) → HOLD(consume) → FETCH.
  - The next FETCH sees the incremented `pc_in`.
- Branch in HOLD at cycle N: REDIRECT in N+1 (`epc`), FETCH in N+2 with `mem_addr` = target.
- Reset asserted mid-operation immediately forces all reset values. Any pending branch or captured word is lost.

## Configuration
- `IFETCH_TIMEOUT_EN` defined:
  - An 8-bit counter runs while in FETCH and clears on ack.
  - When the count reaches `TIMEOUT` with no ack, the block drops `mem_req` and sets `fault`.
  - It then enters FAULT, which it leaves only via reset.
  - In FAULT, `br_take` is ignored and no further outputs change.
- `IFETCH_TIMEOUT_EN` undefined: no counter, `fault` tied 0, FETCH waits indefinitely.

## Test plan
- Reset, zero-wait memory returning `mem_rdata` = `pc_in` ^ 0xA5A5, `ir_ready`=1, PC model from 0 → `ir_out` sequence 0xA5A5, 0xA5A4, 0xA5A7; `ipc` one pulse per word; 3-cycle period.
- `ir_ready`=0 for 5 cycles in HOLD → `ir_valid` and `ir_out` stable, no `ipc`, `mem_req`=0 throughout.
- `br_take` with target 0x0040 in HOLD → one-cycle `epc` with `pc_data`=0x0041; next `mem_addr`=0x0040; no `ipc` for the dropped word.
- `br_take` with target 0x1234 during a 4-wait-state FETCH → ack data discarded, `ir_valid` stays 0, `epc` with `pc_data`=0x1235, refetch at 0x1234. Repeat with `br_take` on the ack cycle itself: same result.
- `br_target`=0xFFFF → `pc_data`=0x0000, PC model loads 0xFFFF, fetch at 0xFFFF. Then `ipc` wraps the PC to 0x0000.
- With `IFETCH_TIMEOUT_EN` and `TIMEOUT`=10, no ack → `fault`=1 and `mem_req`=0 after 10 FETCH cycles; stays there until reset pulse; reset clears `fault`; fetch restarts at 0.

Source files
------------

// File: rtl/ifetch.sv
// ifetch: fetch sequencer between the PC, instruction memory and decoder.
// Define IFETCH_TIMEOUT_EN to build the memory-ack watchdog and FAULT lock-up.
module ifetch #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] pc_in,
    output logic        ipc,
    output logic        epc,
    output logic [15:0] pc_data,
    output logic        mem_req,
    output logic [15:0] mem_addr,
    input  logic        mem_ack,
    input  logic [15:0] mem_rdata,
    output logic [15:0] ir_out,
    output logic        ir_valid,
    input  logic        ir_ready,
    input  logic        br_take,
    input  logic [15:0] br_target,
    output logic        fault
);

    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] FETCH    = 3'd1;
    localparam logic [2:0] HOLD     = 3'd2;
    localparam logic [2:0] REDIRECT = 3'd3;
    localparam logic [2:0] FAULT    = 3'd4;

    if (TIMEOUT == 0 || TIMEOUT > 255) begin : g_bad_timeout
        $error("ifetch: TIMEOUT must be in 1..255");
    end

    logic [2:0]  state_q, state_d;
    logic        mem_req_q, mem_req_d;
    logic [15:0] ir_out_q, ir_out_d;
    logic        ir_valid_q, ir_valid_d;
    logic        ipc_q, ipc_d;
    logic        epc_q, epc_d;
    logic [15:0] pc_data_q, pc_data_d;
    logic        br_pend_q, br_pend_d;
    logic [15:0] br_tgt_q, br_tgt_d;
    logic        tmo;

    always_comb begin
        state_d    = state_q;
        ir_out_d   = ir_out_q;
        ir_valid_d = ir_valid_q;
        pc_data_d  = pc_data_q;
        br_tgt_d   = br_tgt_q;
        br_pend_d  = br_pend_q;
        ipc_d      = 1'b0;

        // A new branch always overrides; otherwise the pending one retires with REDIRECT.
        if (state_q != FAULT && br_take) begin
            br_tgt_d  = br_target;
            br_pend_d = 1'b1;
        end else if (state_q == REDIRECT) begin
            br_pend_d = 1'b0;
        end

        case (state_q)
            IDLE: state_d = FETCH;
            FETCH: begin
                if (tmo) begin
                    state_d = FAULT;
                end else if (mem_ack) begin
                    if (br_pend_q || br_take) begin
                        state_d = REDIRECT;
                    end else begin
                        state_d    = HOLD;
                        ir_out_d   = mem_rdata;
                        ir_valid_d = 1'b1;
                        ipc_d      = 1'b1;
                    end
                end
            end
            HOLD: begin
                if (br_take) begin
                    ir_valid_d = 1'b0;
                    state_d    = REDIRECT;
                end else if (ir_ready) begin
                    ir_valid_d = 1'b0;
                    state_d    = FETCH;
                end
            end
            REDIRECT: state_d = FETCH;
            FAULT:    state_d = FAULT;
            default:  state_d = IDLE;
        endcase

        // The PC loads pc_data - 1, so present the target pre-incremented.
        if (state_d == REDIRECT) begin
            pc_data_d = br_tgt_d + 16'd1;
        end
        epc_d     = (state_d == REDIRECT);
        mem_req_d = (state_d == FETCH);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            mem_req_q  <= 1'b0;
            ir_out_q   <= 16'd0;
            ir_valid_q <= 1'b0;
            ipc_q      <= 1'b0;
            epc_q      <= 1'b0;
            pc_data_q  <= 16'd0;
            br_pend_q  <= 1'b0;
            br_tgt_q   <= 16'd0;
        end else begin
            state_q    <= state_d;
            mem_req_q  <= mem_req_d;
            ir_out_q   <= ir_out_d;
            ir_valid_q <= ir_valid_d;
            ipc_q      <= ipc_d;
            epc_q      <= epc_d;
            pc_data_q  <= pc_data_d;
            br_pend_q  <= br_pend_d;
            br_tgt_q   <= br_tgt_d;
        end
    end

`ifdef IFETCH_TIMEOUT_EN
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

    logic [7:0] cnt_q, cnt_d;
    logic       fault_q;

    always_comb begin
        cnt_d = 8'd0;
        if (state_q == FETCH && !mem_ack) begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    assign tmo = (state_q == FETCH) && !mem_ack && (cnt_q == TMO_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q   <= 8'd0;
            fault_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            fault_q <= fault_q | tmo;
        end
    end

    assign fault = fault_q;
`else
    assign tmo   = 1'b0;
    assign fault = 1'b0;
`endif

    assign ipc      = ipc_q;
    assign epc      = epc_q;
    assign pc_data  = pc_data_q;
    assign mem_req  = mem_req_q;
    assign mem_addr = pc_in;
    assign ir_out   = ir_out_q;
    assign ir_valid = ir_valid_q;

endmodule

// File: tb/tb_ifetch.sv
// Scoreboard bench for ifetch: PC model, synchronous memory model, decoder stimulus.
// Watchdog checks are compiled in when IFETCH_TIMEOUT_EN is defined.
module tb_ifetch;

    logic        clk;
    logic        reset;
    logic [15:0] pc_in;
    logic        ipc;
    logic        epc;
    logic [15:0] pc_data;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic        mem_ack;
    logic [15:0] mem_rdata;
    logic [15:0] ir_out;
    logic        ir_valid;
    logic        ir_ready;
    logic        br_take;
    logic [15:0] br_target;
    logic        fault;

    ifetch #(.TIMEOUT(10)) dut (
        .clk       (clk),
        .reset     (reset),
        .pc_in     (pc_in),
        .ipc       (ipc),
        .epc       (epc),
        .pc_data   (pc_data),
        .mem_req   (mem_req),
        .mem_addr  (mem_addr),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata),
        .ir_out    (ir_out),
        .ir_valid  (ir_valid),
        .ir_ready  (ir_ready),
        .br_take   (br_take),
        .br_target (br_target),
        .fault     (fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;
    int n_ipc  = 0;
    int n_epc  = 0;
    int cyc    = 0;
    int wait_st;
    bit mem_en;
    int req_cyc;
    bit prev_ack;
    bit prev_valid;
    int ipc_t[$];
    logic [15:0] exp_q[$];
    logic [15:0] exp_epc[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic drain(input int lim);
        for (int i = 0; i < lim && exp_q.size() != 0; i++) tick();
        chk("drain", exp_q.size(), 0);
    endtask

    task automatic wait_req(input int lim);
        for (int i = 0; i < lim && !mem_req; i++) tick();
        chk("wait_req", mem_req, 1);
    endtask

    task automatic wait_ack(input int lim);
        for (int i = 0; i < lim && !mem_ack; i++) tick();
        chk("wait_ack", mem_ack, 1);
    endtask

    task automatic wait_epc(input int lim);
        for (int i = 0; i < lim && !epc; i++) tick();
        chk("wait_epc", epc, 1);
    endtask

    // PC model: loads pc_data - 1 on epc, increments on ipc.
    initial begin
        pc_in = 16'h0000;
        forever begin
            @(posedge clk);
            if (reset)     pc_in = 16'h0000;
            else if (epc)  pc_in = pc_data - 16'h0001;
            else if (ipc)  pc_in = pc_in + 16'h0001;
        end
    end

    // Monitor/scoreboard, then synchronous memory: ack in request cycle wait_st+2.
    initial begin
        mem_ack    = 1'b0;
        mem_rdata  = 16'h0000;
        req_cyc    = 0;
        prev_ack   = 1'b0;
        prev_valid = 1'b0;
        forever begin
            @(negedge clk);
            cyc++;
            if (prev_ack) chk("req_low_after_ack", mem_req, 0);
            if (mem_req)  chk("mem_addr_follows_pc", mem_addr, pc_in);
            if (ipc) begin
                n_ipc++;
                ipc_t.push_back(cyc);
            end
            if (ir_valid && !prev_valid) begin
                chk("word_expected", 32'(exp_q.size() != 0), 1);
                chk("ipc_with_word", ipc, 1);
                if (exp_q.size() != 0) chk("ir_out", ir_out, exp_q.pop_front());
            end
            if (epc) begin
                n_epc++;
                chk("epc_excl_ipc", ipc, 0);
                chk("epc_expected", 32'(exp_epc.size() != 0), 1);
                if (exp_epc.size() != 0) chk("pc_data", pc_data, exp_epc.pop_front());
            end
            prev_valid = ir_valid;
            if (mem_req) req_cyc++;
            else         req_cyc = 0;
            mem_ack   = mem_req && mem_en && (req_cyc == wait_st + 2);
            mem_rdata = mem_ack ? (mem_addr ^ 16'hA5A5) : 16'h0BAD;
            prev_ack  = mem_ack;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "tb_ifetch time limit");
    end

    initial begin
        int ipc0;
        int epc0;
        int n;
        reset     = 1'b1;
        ir_ready  = 1'b0;
        br_take   = 1'b0;
        br_target = 16'h0000;
        mem_en    = 1'b1;
        wait_st   = 0;
        repeat (2) tick();
        chk("rst_ipc", ipc, 0);
        chk("rst_epc", epc, 0);
        chk("rst_pc_data", pc_data, 0);
        chk("rst_mem_req", mem_req, 0);
        chk("rst_ir_out", ir_out, 0);
        chk("rst_ir_valid", ir_valid, 0);
        chk("rst_fault", fault, 0);

        // Zero-wait streaming from PC 0 with the decoder always ready
        exp_q.push_back(16'hA5A5);
        exp_q.push_back(16'hA5A4);
        exp_q.push_back(16'hA5A7);
        ir_ready = 1'b1;
        reset    = 1'b0;
        tick();
        chk("req_after_rst", mem_req, 1);
        drain(40);
        ir_ready = 1'b0;
        chk("stream_ipc_cnt", n_ipc, 3);
        chk("period_1", ipc_t.size() > 1 ? ipc_t[1] - ipc_t[0] : 0, 3);
        chk("period_2", ipc_t.size() > 2 ? ipc_t[2] - ipc_t[1] : 0, 3);

        // Decoder stall in HOLD
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("stall_valid", ir_valid, 1);
            chk("stall_ir_out", ir_out, 16'hA5A7);
            chk("stall_ipc", ipc, 0);
            chk("stall_req", mem_req, 0);
        end

        // Branch taken while holding a word
        ipc0 = n_ipc;
        br_take   = 1'b1;
        br_target = 16'h0040;
        exp_epc.push_back(16'h0041);
        exp_q.push_back(16'hA5E5);
        tick();
        br_take = 1'b0;
        chk("hold_br_epc", epc, 1);
        tick();
        chk("hold_br_addr", mem_addr, 16'h0040);
        chk("hold_br_req", mem_req, 1);
        chk("hold_br_no_ipc", n_ipc, ipc0);
        chk("hold_br_valid", ir_valid, 0);
        ir_ready = 1'b1;
        drain(30);
        ir_ready = 1'b0;

        // Branch during a 4-wait-state fetch: acked word is discarded
        wait_st  = 4;
        ir_ready = 1'b1;
        wait_req(10);
        tick();
        br_take   = 1'b1;
        br_target = 16'h1234;
        exp_epc.push_back(16'h1235);
        exp_q.push_back(16'hB791);
        tick();
        br_take = 1'b0;
        ipc0 = n_ipc;
        wait_epc(20);
        chk("fetch_br_no_ipc", n_ipc, ipc0);
        tick();
        chk("fetch_br_addr", mem_addr, 16'h1234);
        drain(40);
        ir_ready = 1'b0;

        // Branch arriving in the ack cycle itself
        ir_ready = 1'b1;
        wait_ack(20);
        br_take   = 1'b1;
        br_target = 16'h1234;
        exp_epc.push_back(16'h1235);
        exp_q.push_back(16'hB791);
        ipc0 = n_ipc;
        tick();
        br_take = 1'b0;
        wait_epc(5);
        chk("ack_br_no_ipc", n_ipc, ipc0);
        tick();
        chk("ack_br_addr", mem_addr, 16'h1234);
        drain(40);
        ir_ready = 1'b0;

        // Reset mid-fetch with a branch pending
        ir_ready = 1'b1;
        wait_req(10);
        tick();
        br_take   = 1'b1;
        br_target = 16'h0777;
        tick();
        br_take = 1'b0;
        reset   = 1'b1;
        tick();
        chk("mid_rst_req", mem_req, 0);
        chk("mid_rst_valid", ir_valid, 0);
        chk("mid_rst_ir_out", ir_out, 0);
        chk("mid_rst_pc_data", pc_data, 0);
        chk("mid_rst_epc", epc, 0);
        wait_st = 0;
        epc0 = n_epc;
        exp_q.push_back(16'hA5A5);
        reset = 1'b0;
        drain(30);
        ir_ready = 1'b0;
        chk("mid_rst_br_lost", n_epc, epc0);

        // Branch to 0xFFFF and PC wrap to 0
        br_take   = 1'b1;
        br_target = 16'hFFFF;
        exp_epc.push_back(16'h0000);
        exp_q.push_back(16'h5A5A);
        exp_q.push_back(16'hA5A5);
        tick();
        br_take = 1'b0;
        wait_epc(5);
        tick();
        chk("wrap_addr", mem_addr, 16'hFFFF);
        ir_ready = 1'b1;
        drain(30);
        ir_ready = 1'b0;

`ifdef IFETCH_TIMEOUT_EN
        // Memory never acks: watchdog trips after TIMEOUT fetch cycles
        mem_en   = 1'b0;
        ir_ready = 1'b1;
        wait_req(10);
        n = 0;
        while (mem_req && n < 40) begin
            n++;
            tick();
        end
        chk("tmo_req_cycles", n, 10);
        chk("tmo_fault", fault, 1);
        chk("tmo_req_low", mem_req, 0);
        br_take   = 1'b1;
        br_target = 16'h0100;
        epc0 = n_epc;
        for (int i = 0; i < 5; i++) begin
            tick();
            br_take = 1'b0;
            chk("fault_sticky", fault, 1);
            chk("fault_req", mem_req, 0);
            chk("fault_valid", ir_valid, 0);
        end
        chk("fault_no_epc", n_epc, epc0);
        reset = 1'b1;
        tick();
        chk("fault_cleared", fault, 0);
        mem_en = 1'b1;
        exp_q.push_back(16'hA5A5);
        reset = 1'b0;
        drain(30);
        ir_ready = 1'b0;
`else
        chk("fault_tied0", fault, 0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
